// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: default widths, the CPU-side FSM
// state encoding, and the read-owner tag layout.
package vram_pkg;

  localparam int ADDR_W_DEF       = 13;
  localparam int DATA_W_DEF       = 8;
  localparam int STARVE_LIMIT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_ACK  = 3'd2,
    WR_ACK  = 3'd3,
    HOLD    = 3'd4
  } state_e;

  // Owner tag of an issued RAM read, laid out as {disp, cpu}.
  typedef logic [1:0] tag_t;

  localparam int   TAG_CPU_BIT  = 0;
  localparam int   TAG_DISP_BIT = 1;
  localparam tag_t TAG_NONE     = 2'b00;
  localparam tag_t TAG_CPU      = 2'b01;
  localparam tag_t TAG_DISP     = 2'b10;

endpackage

// File: rtl/vram_read_tag_pipe.sv
// Two-stage owner tag shift register that steers returning RAM read data to
// either the display or the CPU data register.
module vram_read_tag_pipe
  import vram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  tag_t              issue_tag,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] disp_data,
  output logic [DATA_W-1:0] cpu_rdata
);

  // tag_issue_q lines up with ram_addr, tag_data_q with ram_rdata.
  tag_t tag_issue_q;
  tag_t tag_data_q;

  // NOTE: non-blocking assignments make tag_data_q take the pre-edge value of
  // tag_issue_q, which is exactly the one-cycle shift the pipeline needs.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      tag_issue_q <= TAG_NONE;
      tag_data_q  <= TAG_NONE;
      disp_data   <= '0;
      cpu_rdata   <= '0;
    end else begin
      tag_issue_q <= issue_tag;
      tag_data_q  <= tag_issue_q;
      if (tag_data_q[TAG_DISP_BIT]) disp_data <= ram_rdata;
      if (tag_data_q[TAG_CPU_BIT])  cpu_rdata <= ram_rdata;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port display RAM arbiter: display fetches have absolute priority,
// CPU accesses use a req/ack handshake and are tracked for starvation.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic              disp_rd,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_starved,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int               CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  state_e           state;
  state_e           state_next;
  logic             grant;
  logic             wait_inc;
  logic             ack_next;
  tag_t             issue_tag;
  logic [CNT_W-1:0] wait_cnt;

  // NOTE: reset is synchronous, so it is tested inside the clocked branch and
  // is not part of the sensitivity list.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: each always_comb output is given a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cpu_req && !disp_rd) state_next = cpu_we ? WR_ACK : RD_WAIT;
      RD_WAIT: state_next = RD_ACK;
      RD_ACK:  state_next = HOLD;
      WR_ACK:  state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The RAM port is only contended in IDLE; elsewhere the display may use it freely.
  always_comb begin
    grant     = (state == IDLE) && cpu_req && !disp_rd;
    wait_inc  = (state == IDLE) && cpu_req && disp_rd;
    ack_next  = (state == RD_ACK) || (state == WR_ACK);
    issue_tag = TAG_NONE;
    if (disp_rd)                issue_tag = TAG_DISP;
    else if (grant && !cpu_we)  issue_tag = TAG_CPU;
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
    end else begin
      cpu_ack <= ack_next;
      ram_we  <= 1'b0;
      if (disp_rd) begin
        ram_addr <= disp_addr;
      end else if (grant) begin
        ram_addr  <= cpu_addr;
        ram_we    <= cpu_we;
        ram_wdata <= cpu_wdata;
      end
    end
  end

  // Wait counter saturates at the limit; the starvation flag is sticky until reset.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      cpu_starved <= 1'b0;
    end else if (grant) begin
      wait_cnt <= '0;
    end else if (wait_inc && (wait_cnt != LIMIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == LIMIT_M1) cpu_starved <= 1'b1;
    end
  end

  vram_read_tag_pipe #(
    .DATA_W (DATA_W)
  ) u_read_tag_pipe (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .issue_tag (issue_tag),
    .ram_rdata (ram_rdata),
    .disp_data (disp_data),
    .cpu_rdata (cpu_rdata)
  );

endmodule
